booth_digit_decoder: RTL and testbench

BOOTH_DIGIT_DECODER -- requirements
Module: booth_digit_decoder

---
 rtl/booth_digit_decoder_pkg.sv | 23 ++
 rtl/booth_digit_value.sv | 25 ++
 rtl/booth_digit_decoder.sv | 132 +++++++++++++
 tb/tb_booth_digit_decoder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/booth_digit_decoder_pkg.sv
// Shared definitions for the radix-4 Booth digit decoder:
// Booth code constants, FSM state encoding and the result-width helper.
package booth_digit_decoder_pkg;

    // Legal radix-4 Booth codes: bit2 = sign, bits1:0 = magnitude
    localparam logic [2:0] ZERO = 3'b000;
    localparam logic [2:0] POS1 = 3'b001;
    localparam logic [2:0] POS2 = 3'b010;
    localparam logic [2:0] NEG1 = 3'b101;
    localparam logic [2:0] NEG2 = 3'b110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Each radix-4 digit carries two bits of weight
    function automatic int booth_width(input int num_digits);
        return 2 * num_digits;
    endfunction

endpackage

// File: rtl/booth_digit_value.sv
// Combinational map from a 3-bit Booth code to its signed value (-2..+2)
// plus a flag for the three codes that have no meaning (011, 100, 111).
module booth_digit_value
    import booth_digit_decoder_pkg::*;
(
    input  logic              [2:0] code,
    output logic signed       [2:0] value,
    output logic                    illegal
);

    // Decode the code; illegal codes map to zero so they never disturb a sum
    always_comb begin
        value   = 3'sd0;
        illegal = 1'b0;
        case (code)
            ZERO:    value = 3'sd0;
            POS1:    value = 3'sd1;
            POS2:    value = 3'sd2;
            NEG1:    value = -3'sd1;
            NEG2:    value = -3'sd2;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/booth_digit_decoder.sv
// Radix-4 Booth digit decoder: accepts NUM_DIGITS Booth codes LSB-first,
// accumulates sum(d_i * 4^i) modulo 2^W and presents the word with a
// valid/ready handshake.
// Optional feature macro: BOOTH_DEC_ERR_EN adds result_err, a sticky flag
// raised when any code in the frame was illegal.
module booth_digit_decoder
    import booth_digit_decoder_pkg::*;
#(
    parameter int NUM_DIGITS = 3,
    parameter int W          = booth_width(NUM_DIGITS)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         digit_valid,
    output logic         digit_ready,
    input  logic [2:0]   digit,
    output logic         result_valid,
    input  logic         result_ready,
    output logic [W-1:0] result
`ifdef BOOTH_DEC_ERR_EN
    ,
    output logic         result_err
`endif
);

    localparam int CW = $clog2(NUM_DIGITS + 1);

    state_t          state_reg, state_next;
    logic [W-1:0]    acc_reg, acc_next;
    logic [CW-1:0]   count_reg, count_next;
`ifdef BOOTH_DEC_ERR_EN
    logic            err_reg, err_next;
`endif

    logic signed [2:0] digit_value;
    logic              digit_illegal;
    logic [W-1:0]      value_ext;
    logic [W-1:0]      term;
    logic              digit_fire;
    logic              last_digit;

    booth_digit_value u_value (
        .code    (digit),
        .value   (digit_value),
        .illegal (digit_illegal)
    );

    // Sign-extend the digit to W bits and weight it by 4^count (shift by 2*count);
    // illegal codes are forced to contribute nothing
    assign value_ext  = {{(W-3){digit_value[2]}}, digit_value};
    assign term       = digit_illegal ? '0 : (value_ext << {count_reg, 1'b0});
    assign digit_fire = digit_valid && digit_ready;
    assign last_digit = (count_reg == CW'(NUM_DIGITS - 1));

    assign digit_ready  = (state_reg != DONE);
    assign result_valid = (state_reg == DONE);
    assign result       = acc_reg;
`ifdef BOOTH_DEC_ERR_EN
    assign result_err   = err_reg;
`endif

    // State, accumulator, digit counter and error flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            count_reg <= '0;
`ifdef BOOTH_DEC_ERR_EN
            err_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            count_reg <= count_next;
`ifdef BOOTH_DEC_ERR_EN
            err_reg   <= err_next;
`endif
        end
    end

    // Next-state logic: flush wins over everything, otherwise accumulate or drain
    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        count_next = count_reg;
`ifdef BOOTH_DEC_ERR_EN
        err_next   = err_reg;
`endif
        if (flush) begin
            state_next = IDLE;
            acc_next   = '0;
            count_next = '0;
`ifdef BOOTH_DEC_ERR_EN
            err_next   = 1'b0;
`endif
        end else begin
            case (state_reg)
                // IDLE holds acc = 0 and count = 0, so it shares ACCUM's datapath
                IDLE, ACCUM: begin
                    if (digit_fire) begin
                        acc_next   = acc_reg + term;
                        count_next = count_reg + CW'(1);
`ifdef BOOTH_DEC_ERR_EN
                        err_next   = err_reg | digit_illegal;
`endif
                        state_next = last_digit ? DONE : ACCUM;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        state_next = IDLE;
                        acc_next   = '0;
                        count_next = '0;
`ifdef BOOTH_DEC_ERR_EN
                        err_next   = 1'b0;
`endif
                    end
                end
                default: begin
                    state_next = IDLE;
                    acc_next   = '0;
                    count_next = '0;
`ifdef BOOTH_DEC_ERR_EN
                    err_next   = 1'b0;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_digit_decoder.sv
// Scoreboard testbench for booth_digit_decoder (NUM_DIGITS = 3, W = 6).
// Expected words are pushed when a frame is driven and popped by a monitor
// when the DUT completes a result handshake.
module tb_booth_digit_decoder;

    localparam int ND = 3;
    localparam int WW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          digit_valid;
    logic          digit_ready;
    logic [2:0]    digit;
    logic          result_valid;
    logic          result_ready;
    logic [WW-1:0] result;
`ifdef BOOTH_DEC_ERR_EN
    logic          result_err;
`endif

    typedef struct packed {
        logic [WW-1:0] value;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    booth_digit_decoder #(.NUM_DIGITS(ND)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .digit_valid  (digit_valid),
        .digit_ready  (digit_ready),
        .digit        (digit),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result)
`ifdef BOOTH_DEC_ERR_EN
        ,
        .result_err   (result_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int code_val(input logic [2:0] c);
        case (c)
            3'b001:  return 1;
            3'b010:  return 2;
            3'b101:  return -1;
            3'b110:  return -2;
            default: return 0;
        endcase
    endfunction

    function automatic logic code_bad(input logic [2:0] c);
        return (c == 3'b011) || (c == 3'b100) || (c == 3'b111);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare each accepted result against the scoreboard head
    always @(negedge clk) begin
        if (!rst && result_valid && result_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'(result), 32'hDEAD);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("result %06b expected %06b", result, e.value);
                check("result", 32'(result), 32'(e.value));
`ifdef BOOTH_DEC_ERR_EN
                check("result_err", 32'(result_err), 32'(e.err));
`endif
            end
        end
    end

    // Push the expected word for a frame built from three codes
    task automatic push_expected(input logic [2:0] d0, input logic [2:0] d1, input logic [2:0] d2);
        exp_t e;
        int   s;
        s       = code_val(d0) + 4 * code_val(d1) + 16 * code_val(d2);
        e.value = WW'(s);
        e.err   = code_bad(d0) | code_bad(d1) | code_bad(d2);
        exp_q.push_back(e);
    endtask

    // Drive one digit; the transfer happens at the next rising edge
    task automatic send_digit(input logic [2:0] d);
        digit_valid = 1'b1;
        digit       = d;
        check("digit_ready", 32'(digit_ready), 32'd1);
        tick;
        digit_valid = 1'b0;
    endtask

    // Full frame with result_ready held high; optional gap after digit 0
    task automatic run_frame(input logic [2:0] d0, input logic [2:0] d1, input logic [2:0] d2,
                             input int gap);
        push_expected(d0, d1, d2);
        $display("frame %03b %03b %03b gap=%0d", d0, d1, d2, gap);
        send_digit(d0);
        repeat (gap) begin
            tick;
            check("gap_valid", 32'(result_valid), 32'd0);
        end
        send_digit(d1);
        check("mid_valid", 32'(result_valid), 32'd0);
        send_digit(d2);
        check("latency_valid", 32'(result_valid), 32'd1);
        tick;
        check("one_cycle_valid", 32'(result_valid), 32'd0);
        check("ready_after", 32'(digit_ready), 32'd1);
    endtask

    initial begin
        rst          = 1'b1;
        flush        = 1'b0;
        digit_valid  = 1'b0;
        digit        = 3'b000;
        result_ready = 1'b1;
        tick;
        tick;
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_ready", 32'(digit_ready), 32'd1);
        check("rst_result", 32'(result), 32'd0);
        rst = 1'b0;
        tick;

        // Directed frames
        run_frame(3'b001, 3'b101, 3'b001, 0);   // +13
        run_frame(3'b000, 3'b000, 3'b101, 0);   // -16
        run_frame(3'b010, 3'b010, 3'b010, 2);   // 42 wraps to -22
        run_frame(3'b011, 3'b001, 3'b000, 0);   // illegal code -> 4
        run_frame(3'b110, 3'b001, 3'b010, 1);   // clean frame after an illegal one

        // Back-pressure: result held, no digit consumed while stalled
        result_ready = 1'b0;
        push_expected(3'b001, 3'b001, 3'b001);
        $display("stall frame 001 001 001");
        send_digit(3'b001);
        send_digit(3'b001);
        send_digit(3'b001);
        digit_valid = 1'b1;
        digit       = 3'b001;
        for (int i = 0; i < 4; i++) begin
            check("stall_valid", 32'(result_valid), 32'd1);
            check("stall_result", 32'(result), 32'h15);
            check("stall_ready", 32'(digit_ready), 32'd0);
            tick;
        end
        digit_valid  = 1'b0;
        result_ready = 1'b1;
        tick;
        check("stall_release", 32'(result_valid), 32'd0);
        run_frame(3'b001, 3'b000, 3'b000, 0);   // proves the stalled digit was dropped

        // Flush mid-frame
        $display("partial 001 010 then flush");
        send_digit(3'b001);
        send_digit(3'b010);
        flush       = 1'b1;
        digit_valid = 1'b1;
        digit       = 3'b010;
        tick;
        flush       = 1'b0;
        digit_valid = 1'b0;
        check("flush_valid", 32'(result_valid), 32'd0);
        check("flush_result", 32'(result), 32'd0);
        run_frame(3'b000, 3'b000, 3'b001, 0);   // +16

        // Asynchronous reset mid-frame
        $display("partial 001 010 then rst");
        send_digit(3'b001);
        send_digit(3'b010);
        #2 rst = 1'b1;
        #1;
        check("async_rst_result", 32'(result), 32'd0);
        check("async_rst_ready", 32'(digit_ready), 32'd1);
        tick;
        rst = 1'b0;
        tick;
        run_frame(3'b000, 3'b000, 3'b001, 0);   // +16

        // Random frames across all eight codes
        for (int f = 0; f < 8; f++) begin
            run_frame(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                      3'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
        end

        repeat (3) tick;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
